// File: rtl/instr_sequencer_if.sv
// Control/handshake bundle between instr_sequencer and the RV32IM datapath.
// Handshake: FETCH_ENABLED/MEMORY_ENABLED act as a held request (valid); the access completes in the first cycle its IMEM_READY/DMEM_READY (ready) is high, and the enable drops on the following cycle.
interface instr_sequencer_if;
  logic        START;
  logic        STOP;
  logic        IMEM_READY;
  logic        DMEM_READY;
  logic        CONDITIONAL_JUMP;
  logic        MRET;
  logic        IS_MULDIV;
  logic        MEM_ACCESS;
  logic        BRANCH_TAKEN;
  logic        FETCH_ENABLED;
  logic        DECODER_ENABLED;
  logic        EXECUTE_ENABLED;
  logic        MEMORY_ENABLED;
  logic        WRITEBACK_ENABLED;
  logic        PC_WE;
  logic [1:0]  PC_SEL;
  logic        BUSY;
  logic [2:0]  STATE;
  logic [31:0] RETIRED;

  // The sequencer side.
  modport master (
    input  START, STOP, IMEM_READY, DMEM_READY, CONDITIONAL_JUMP, MRET,
           IS_MULDIV, MEM_ACCESS, BRANCH_TAKEN,
    output FETCH_ENABLED, DECODER_ENABLED, EXECUTE_ENABLED, MEMORY_ENABLED,
           WRITEBACK_ENABLED, PC_WE, PC_SEL, BUSY, STATE, RETIRED
  );

  // The datapath / environment side.
  modport slave (
    output START, STOP, IMEM_READY, DMEM_READY, CONDITIONAL_JUMP, MRET,
           IS_MULDIV, MEM_ACCESS, BRANCH_TAKEN,
    input  FETCH_ENABLED, DECODER_ENABLED, EXECUTE_ENABLED, MEMORY_ENABLED,
           WRITEBACK_ENABLED, PC_WE, PC_SEL, BUSY, STATE, RETIRED
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM for the RV32IM core: stage enables, PC source select, retire counter.
// Define INSTR_SEQ_MULDIV_EN to hold EXECUTE for MULDIV_CYCLES cycles on M-extension ops.
module instr_sequencer #(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic              CLK,
  input  logic              RST,
  instr_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5
  } state_t;

  state_t      state;
  state_t      nxt;
  logic        jump_f;
  logic        mret_f;
  logic        taken_f;
  logic        taken_nxt;
  logic        exec_last;
  logic [1:0]  pc_sel_nxt;

  logic        fetch_q;
  logic        decode_q;
  logic        execute_q;
  logic        memory_q;
  logic        writeback_q;
  logic        pc_we_q;
  logic        busy_q;
  logic [1:0]  pc_sel_q;
  logic [31:0] retired_q;

`ifdef INSTR_SEQ_MULDIV_EN
  localparam logic [7:0] CNT_LOAD = 8'(MULDIV_CYCLES - 1);

  // The counter is zero on entry to EXECUTE, so zero there marks the first cycle.
  logic [7:0] cnt;
  logic       exec_first;

  assign exec_first = (cnt == 8'd0);
  assign exec_last  = exec_first ? !bus.IS_MULDIV : (cnt == 8'd1);
`else
  logic unused_is_muldiv;

  assign unused_is_muldiv = bus.IS_MULDIV;
  assign exec_last        = 1'b1;
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:      if (bus.START) nxt = S_FETCH;
      S_FETCH:     if (bus.IMEM_READY) nxt = S_DECODE;
      S_DECODE:    nxt = S_EXECUTE;
      S_EXECUTE:   if (exec_last) nxt = bus.MEM_ACCESS ? S_MEMORY : S_WRITEBACK;
      S_MEMORY:    if (bus.DMEM_READY) nxt = S_WRITEBACK;
      S_WRITEBACK: nxt = bus.STOP ? S_IDLE : S_FETCH;
      default:     nxt = S_IDLE;
    endcase
  end

  // The branch outcome is only trustworthy on the final EXECUTE cycle.
  always_comb begin
    taken_nxt = taken_f;
    if (state == S_EXECUTE && exec_last) taken_nxt = jump_f & bus.BRANCH_TAKEN;
  end

  always_comb begin
    pc_sel_nxt = 2'b00;
    if (nxt == S_WRITEBACK) begin
      if (mret_f)         pc_sel_nxt = 2'b10;
      else if (taken_nxt) pc_sel_nxt = 2'b01;
      else                pc_sel_nxt = 2'b00;
    end
  end

  // Outputs are registered from the next state so each is a clean decode of the state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      jump_f      <= 1'b0;
      mret_f      <= 1'b0;
      taken_f     <= 1'b0;
      fetch_q     <= 1'b0;
      decode_q    <= 1'b0;
      execute_q   <= 1'b0;
      memory_q    <= 1'b0;
      writeback_q <= 1'b0;
      pc_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      pc_sel_q    <= 2'b00;
      retired_q   <= 32'd0;
`ifdef INSTR_SEQ_MULDIV_EN
      cnt         <= 8'd0;
`endif
    end else begin
      state       <= nxt;
      taken_f     <= taken_nxt;
      fetch_q     <= (nxt == S_FETCH);
      decode_q    <= (nxt == S_DECODE);
      execute_q   <= (nxt == S_EXECUTE);
      memory_q    <= (nxt == S_MEMORY);
      writeback_q <= (nxt == S_WRITEBACK);
      pc_we_q     <= (nxt == S_WRITEBACK);
      busy_q      <= (nxt != S_IDLE);
      pc_sel_q    <= pc_sel_nxt;
      if (state == S_DECODE) begin
        jump_f <= bus.CONDITIONAL_JUMP;
        mret_f <= bus.MRET;
      end
      if (state == S_WRITEBACK) retired_q <= retired_q + 32'd1;
`ifdef INSTR_SEQ_MULDIV_EN
      if (state == S_EXECUTE) begin
        if (exec_first) cnt <= bus.IS_MULDIV ? CNT_LOAD : 8'd0;
        else            cnt <= cnt - 8'd1;
      end
`endif
    end
  end

  assign bus.FETCH_ENABLED     = fetch_q;
  assign bus.DECODER_ENABLED   = decode_q;
  assign bus.EXECUTE_ENABLED   = execute_q;
  assign bus.MEMORY_ENABLED    = memory_q;
  assign bus.WRITEBACK_ENABLED = writeback_q;
  assign bus.PC_WE             = pc_we_q;
  assign bus.PC_SEL            = pc_sel_q;
  assign bus.BUSY              = busy_q;
  assign bus.STATE             = state;
  assign bus.RETIRED           = retired_q;

  a_cycles_range: assert property (@(posedge CLK)
    (MULDIV_CYCLES >= 2) && (MULDIV_CYCLES <= 255));

  a_onehot_enables: assert property (@(posedge CLK) disable iff (RST)
    $onehot0({fetch_q, decode_q, execute_q, memory_q, writeback_q}));

  a_pc_sel_wb_only: assert property (@(posedge CLK) disable iff (RST)
    !pc_we_q |-> (pc_sel_q == 2'b00));

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table-driven instructions, scoreboard of per-instruction
// timing/PC_SEL expectations, plus hand sequences for reset, wrap and stop.
module tb_instr_sequencer;
  localparam int MD_CYCLES = 32;
`ifdef INSTR_SEQ_MULDIV_EN
  localparam int EXP_MD_EXEC = MD_CYCLES;
`else
  localparam int EXP_MD_EXEC = 1;
`endif
  localparam int W  = 34;
  localparam int NV = 12;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  instr_sequencer_if bus();

  instr_sequencer #(.MULDIV_CYCLES(MD_CYCLES)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         imem_wait;
    int         dmem_wait;
    bit         mem;
    bit         md;
    bit         cj;
    bit         mret;
    bit         bt;
    logic [1:0] pc_sel;
  } vec_t;

  // ---------------- scoreboard ----------------
  // Record: {pc_sel, total cycles, fetch cycles, execute cycles, memory cycles}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rec;

  function automatic logic [W-1:0] expect_of(input vec_t v);
    int f_c;
    int e_c;
    int m_c;
    int t_c;
    f_c = v.imem_wait + 1;
    e_c = v.md ? EXP_MD_EXEC : 1;
    m_c = v.mem ? v.dmem_wait + 1 : 0;
    t_c = f_c + 1 + e_c + m_c + 1;
    return {v.pc_sel, 8'(t_c), 8'(f_c), 8'(e_c), 8'(m_c)};
  endfunction

  int          cyc_c, fetch_c, dec_c, exec_c, mem_c;
  int unsigned retire_count;
  logic [31:0] retired_base;

  always @(negedge CLK) begin
    if (RST) begin
      cyc_c = 0; fetch_c = 0; dec_c = 0; exec_c = 0; mem_c = 0;
      retire_count = 0;
    end else begin
      chk("onehot_enables", 32'($countones({bus.FETCH_ENABLED, bus.DECODER_ENABLED,
          bus.EXECUTE_ENABLED, bus.MEMORY_ENABLED, bus.WRITEBACK_ENABLED}) <= 1), 32'd1);
      chk("busy_vs_state", 32'(bus.BUSY), 32'(bus.STATE != 3'd0));
      if (!bus.PC_WE) chk("pc_sel_outside_wb", 32'(bus.PC_SEL), 32'd0);
      chk("retired", bus.RETIRED, retired_base + retire_count);
      if (bus.BUSY) cyc_c++;
      fetch_c += int'(bus.FETCH_ENABLED);
      dec_c   += int'(bus.DECODER_ENABLED);
      exec_c  += int'(bus.EXECUTE_ENABLED);
      mem_c   += int'(bus.MEMORY_ENABLED);
      if (bus.PC_WE) begin
        chk("wb_enable", 32'(bus.WRITEBACK_ENABLED), 32'd1);
        chk("retire_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_rec = exp_q.pop_front();
          chk("pc_sel", 32'(bus.PC_SEL), 32'(exp_rec[33:32]));
          chk("latency", cyc_c, 32'(exp_rec[31:24]));
          chk("fetch_cycles", fetch_c, 32'(exp_rec[23:16]));
          chk("execute_cycles", exec_c, 32'(exp_rec[15:8]));
          chk("memory_cycles", mem_c, 32'(exp_rec[7:0]));
          chk("decode_pulses", dec_c, 32'd1);
        end
        cyc_c = 0; fetch_c = 0; dec_c = 0; exec_c = 0; mem_c = 0;
        retire_count++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.START = 0; bus.STOP = 0; bus.IMEM_READY = 0; bus.DMEM_READY = 0;
    bus.CONDITIONAL_JUMP = 0; bus.MRET = 0; bus.IS_MULDIV = 0;
    bus.MEM_ACCESS = 0; bus.BRANCH_TAKEN = 0;
  endtask

  // Called in the instruction's first FETCH cycle; returns one cycle after its writeback.
  task automatic run_instr(input vec_t v, input bit stop);
    int  f = 0;
    int  m = 0;
    int  e = 0;
    int  guard = 0;
    bit  done = 0;
    int  exp_exec;
    exp_exec = v.md ? EXP_MD_EXEC : 1;
    exp_q.push_back(expect_of(v));
    while (!done) begin
      bus.START            = 1'($urandom_range(0, 1));
      bus.STOP             = 1'($urandom_range(0, 1));
      bus.IMEM_READY       = 1'($urandom_range(0, 1));
      bus.DMEM_READY       = 1'($urandom_range(0, 1));
      bus.CONDITIONAL_JUMP = 1'($urandom_range(0, 1));
      bus.MRET             = 1'($urandom_range(0, 1));
      bus.IS_MULDIV        = 1'($urandom_range(0, 1));
      bus.MEM_ACCESS       = 1'($urandom_range(0, 1));
      bus.BRANCH_TAKEN     = 1'($urandom_range(0, 1));
      case (bus.STATE)
        3'd1: begin bus.IMEM_READY = (f == v.imem_wait); f++; end
        3'd2: begin bus.CONDITIONAL_JUMP = v.cj; bus.MRET = v.mret; end
        3'd3: begin
          e++;
          bus.IS_MULDIV  = v.md;
          bus.MEM_ACCESS = v.mem;
          if (e == exp_exec) bus.BRANCH_TAKEN = v.bt;
        end
        3'd4: begin bus.DMEM_READY = (m == v.dmem_wait); m++; end
        3'd5: begin bus.STOP = stop; done = 1; end
        default: ;
      endcase
      guard++;
      if (guard > 300) begin
        chk("instr_timeout_cycles", guard, 32'd300);
        done = 1;
      end
      @(negedge CLK);
    end
    clear_inputs();
  endtask

  // ---------------- test ----------------
  vec_t       vecs[NV];
  vec_t       addi;
  vec_t       rv;
  logic [2:0] trace[13];
  int         g;

  initial begin
    addi     = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[0]  = '{5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[1]  = '{0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[2]  = '{0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[3]  = '{0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01};
    vecs[4]  = '{0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[5]  = '{0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10};
    vecs[6]  = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10};
    vecs[7]  = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[8]  = '{0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[9]  = '{1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
    vecs[10] = '{2, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01};
    vecs[11] = '{0, 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10};
    trace = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd2, 3'd3, 3'd5,
              3'd1, 3'd2, 3'd3, 3'd5, 3'd1};

    clear_inputs();
    retired_base = 32'd0;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_state", 32'(bus.STATE), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_enables", 32'({bus.FETCH_ENABLED, bus.DECODER_ENABLED, bus.EXECUTE_ENABLED,
        bus.MEMORY_ENABLED, bus.WRITEBACK_ENABLED, bus.PC_WE}), 32'd0);
    chk("rst_pc_sel", 32'(bus.PC_SEL), 32'd0);
    chk("rst_retired", bus.RETIRED, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_without_start", 32'(bus.STATE), 32'd0);

    // Three back-to-back zero-wait addi instructions.
    repeat (3) exp_q.push_back(expect_of(addi));
    bus.IMEM_READY = 1'b1;
    bus.START      = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge CLK);
      bus.START = 1'b0;
      if (i == 11) bus.IMEM_READY = 1'b0;
      chk("addi_state_trace", 32'(bus.STATE), 32'(trace[i]));
    end
    chk("addi_retired_after_12", bus.RETIRED, 32'd3);

    for (int i = 0; i < NV; i++) run_instr(vecs[i], 1'b0);

    for (int i = 0; i < 6; i++) begin
      rv.imem_wait = $urandom_range(0, 3);
      rv.dmem_wait = $urandom_range(0, 3);
      rv.mem       = 1'($urandom_range(0, 1));
      rv.md        = 1'($urandom_range(0, 1));
      rv.cj        = 1'($urandom_range(0, 1));
      rv.mret      = 1'($urandom_range(0, 1));
      rv.bt        = 1'($urandom_range(0, 1));
      rv.pc_sel    = rv.mret ? 2'b10 : ((rv.cj && rv.bt) ? 2'b01 : 2'b00);
      run_instr(rv, 1'b0);
    end

    // Retire counter wrap, then STOP at that writeback.
    #1 force dut.retired_q = 32'hFFFF_FFFF;
    retired_base = 32'hFFFF_FFFF - retire_count;
    #1 release dut.retired_q;
    run_instr(addi, 1'b1);
    chk("wrap_retired", bus.RETIRED, 32'd0);
    chk("stop_busy", 32'(bus.BUSY), 32'd0);
    chk("stop_state", 32'(bus.STATE), 32'd0);
    repeat (3) begin
      @(negedge CLK);
      chk("stay_idle_after_stop", 32'(bus.STATE), 32'd0);
    end

    // Asynchronous reset while waiting in MEMORY.
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START      = 1'b0;
    bus.IMEM_READY = 1'b1;
    bus.MEM_ACCESS = 1'b1;
    g = 0;
    while (bus.STATE != 3'd4 && g < 20) begin
      @(negedge CLK);
      g++;
    end
    chk("reach_memory", 32'(bus.STATE), 32'd4);
    chk("memory_enable", 32'(bus.MEMORY_ENABLED), 32'd1);
    #2 RST = 1'b1;
    retired_base = 32'd0;
    #1;
    chk("async_rst_state", 32'(bus.STATE), 32'd0);
    chk("async_rst_busy", 32'(bus.BUSY), 32'd0);
    chk("async_rst_enables", 32'({bus.FETCH_ENABLED, bus.DECODER_ENABLED, bus.EXECUTE_ENABLED,
        bus.MEMORY_ENABLED, bus.WRITEBACK_ENABLED, bus.PC_WE}), 32'd0);
    chk("async_rst_retired", bus.RETIRED, 32'd0);
    @(negedge CLK);
    #2 RST = 1'b0;
    clear_inputs();
    bus.IMEM_READY = 1'b1;
    bus.DMEM_READY = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      chk("idle_until_start", 32'(bus.STATE), 32'd0);
    end
    clear_inputs();
    bus.START = 1'b1;
    @(negedge CLK);
    run_instr(addi, 1'b1);
    chk("restart_retired", bus.RETIRED, 32'd1);

    @(negedge CLK);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
